// File: rtl/snake_pkg.sv
// Shared game-grid types: default grid size, coordinate widths, food FSM states, cell struct.
// Latency: none (declarations only).
// Backpressure: n/a.
package snake_pkg;

   localparam int GRID_W_DEF = 16;
   localparam int GRID_H_DEF = 8;
   localparam int IDX_W      = 7;   // width of the LFSR sample / linear cell index

   // Coordinate width for a grid dimension; never narrower than one bit.
   function automatic int coord_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   localparam int XW = coord_w(GRID_W_DEF);
   localparam int YW = coord_w(GRID_H_DEF);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SAMPLE = 2'd1,
      QUERY  = 2'd2,
      SCAN   = 2'd3
   } state_t;

   // Cell coordinate as exchanged with the snake body store.
   typedef struct packed {
      logic [YW-1:0] y;
      logic [XW-1:0] x;
   } cell_t;

endpackage

// File: rtl/food_spawn_ctrl_if.sv
// Bundle of spawn request, occupancy query handshake and food result for food_spawn_ctrl.
// Latency: none (wiring only).
// Backpressure: query held by o_QryVld until i_QryAck; i_Spawn is dropped while o_Busy=1.
interface food_spawn_ctrl_if #(
   parameter int COL_W = 4,
   parameter int ROW_W = 3
);
   logic             i_Spawn;
   logic [6:0]       i_RandNum;
   logic             o_QryVld;
   logic [COL_W-1:0] o_QryX;
   logic [ROW_W-1:0] o_QryY;
   logic             i_QryAck;
   logic             i_QryOcc;
   logic             o_FoodVld;
   logic [COL_W-1:0] o_FoodX;
   logic [ROW_W-1:0] o_FoodY;
   logic             o_Busy;
   logic             o_BoardFull;

   // Controller side.
   modport master (
      input  i_Spawn, i_RandNum, i_QryAck, i_QryOcc,
      output o_QryVld, o_QryX, o_QryY, o_FoodVld, o_FoodX, o_FoodY, o_Busy, o_BoardFull
   );

   // Game FSM / LFSR / body-store side.
   modport slave (
      output i_Spawn, i_RandNum, i_QryAck, i_QryOcc,
      input  o_QryVld, o_QryX, o_QryY, o_FoodVld, o_FoodX, o_FoodY, o_Busy, o_BoardFull
   );
endinterface

// File: rtl/food_idx_map.sv
// Maps a linear cell index to column/row and flags indices beyond the grid.
// Latency: combinational.
// Backpressure: none.
module food_idx_map
   import snake_pkg::*;
#(
   parameter int GRID_W = GRID_W_DEF,
   parameter int GRID_H = GRID_H_DEF,
   parameter int COL_W  = coord_w(GRID_W),
   parameter int ROW_W  = coord_w(GRID_H)
) (
   input  logic [IDX_W-1:0] idx,
   output logic [COL_W-1:0] cell_x,
   output logic [ROW_W-1:0] cell_y,
   output logic             in_grid
);
   localparam int CELLS = GRID_W * GRID_H;

   // GRID_W is a power of two, so the column is the low bits and the row the rest.
   always_comb begin
      cell_x  = idx[COL_W-1:0];
      cell_y  = ROW_W'(idx >> COL_W);
      in_grid = ({1'b0, idx} < 8'(CELLS));
   end
endmodule

// File: rtl/food_spawn_ctrl.sv
// Picks a free grid cell for food from LFSR samples, retrying on occupied/out-of-grid cells.
// Latency: 3 edges from i_Spawn to o_FoodVld when the first query is acked free immediately.
// Backpressure: query held until i_QryAck; i_Spawn ignored while busy. FOOD_SCAN_FALLBACK_EN adds linear scan.
module food_spawn_ctrl
   import snake_pkg::*;
#(
   parameter int GRID_W    = GRID_W_DEF,
   parameter int GRID_H    = GRID_H_DEF,
   parameter int MAX_TRIES = 32
) (
   input  logic              i_Clk,
   input  logic              i_Rst,
   food_spawn_ctrl_if.master bus
);
   localparam int COL_W = coord_w(GRID_W);
   localparam int ROW_W = coord_w(GRID_H);
   localparam int CELLS = GRID_W * GRID_H;

   state_t           state_q, state_d;
   logic [7:0]       try_q, try_d;
   logic [IDX_W-1:0] idx_q, idx_d;          // last in-grid candidate / current scan cell
   logic             food_vld_q, food_vld_d;
   logic [COL_W-1:0] food_x_q, food_x_d;
   logic [ROW_W-1:0] food_y_q, food_y_d;
   logic             full_q, full_d;

   logic [IDX_W-1:0] map_idx;
   logic [COL_W-1:0] map_x;
   logic [ROW_W-1:0] map_y;
   logic             map_in_grid;
   logic [7:0]       try_inc;
   logic             tries_done;
   logic             qry_vld;

`ifdef FOOD_SCAN_FALLBACK_EN
   logic [7:0]       scan_q, scan_d;        // occupied cells seen since the scan started
   logic [7:0]       idx_plus;
   logic [IDX_W-1:0] idx_wrap;
`endif

   // SAMPLE classifies the fresh LFSR value; every other state maps the held index.
   assign map_idx = (state_q == SAMPLE) ? bus.i_RandNum : idx_q;

   food_idx_map #(
      .GRID_W (GRID_W),
      .GRID_H (GRID_H),
      .COL_W  (COL_W),
      .ROW_W  (ROW_W)
   ) u_map (
      .idx     (map_idx),
      .cell_x  (map_x),
      .cell_y  (map_y),
      .in_grid (map_in_grid)
   );

   assign try_inc    = (try_q == 8'hFF) ? try_q : try_q + 8'd1;
   assign tries_done = (try_inc >= 8'(MAX_TRIES));

`ifdef FOOD_SCAN_FALLBACK_EN
   assign idx_plus = {1'b0, idx_q} + 8'd1;
   assign idx_wrap = (idx_plus == 8'(CELLS)) ? '0 : idx_plus[IDX_W-1:0];
`endif

   // State and datapath registers; async reset drops the query immediately.
   always_ff @(posedge i_Clk or negedge i_Rst) begin
      if (!i_Rst) begin
         state_q    <= IDLE;
         try_q      <= '0;
         idx_q      <= '0;
         food_vld_q <= 1'b0;
         food_x_q   <= '0;
         food_y_q   <= '0;
         full_q     <= 1'b0;
`ifdef FOOD_SCAN_FALLBACK_EN
         scan_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         try_q      <= try_d;
         idx_q      <= idx_d;
         food_vld_q <= food_vld_d;
         food_x_q   <= food_x_d;
         food_y_q   <= food_y_d;
         full_q     <= full_d;
`ifdef FOOD_SCAN_FALLBACK_EN
         scan_q     <= scan_d;
`endif
      end
   end

   // Next-state: random candidates until one is free, optionally falling back to a scan.
   always_comb begin
      state_d    = state_q;
      try_d      = try_q;
      idx_d      = idx_q;
      food_vld_d = food_vld_q;
      food_x_d   = food_x_q;
      food_y_d   = food_y_q;
      full_d     = full_q;
`ifdef FOOD_SCAN_FALLBACK_EN
      scan_d     = scan_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.i_Spawn) begin
               food_vld_d = 1'b0;
               full_d     = 1'b0;
               try_d      = '0;
               idx_d      = '0;
               state_d    = SAMPLE;
            end
         end
         SAMPLE: begin
            if (map_in_grid) begin
               idx_d   = bus.i_RandNum;
               state_d = QUERY;
            end else begin
               try_d = try_inc;
`ifdef FOOD_SCAN_FALLBACK_EN
               if (tries_done) begin
                  idx_d   = idx_wrap;
                  scan_d  = '0;
                  state_d = SCAN;
               end
`endif
            end
         end
         QUERY: begin
            if (bus.i_QryAck) begin
               if (!bus.i_QryOcc) begin
                  food_x_d   = map_x;
                  food_y_d   = map_y;
                  food_vld_d = 1'b1;
                  state_d    = IDLE;
               end else begin
                  try_d   = try_inc;
                  state_d = SAMPLE;
`ifdef FOOD_SCAN_FALLBACK_EN
                  if (tries_done) begin
                     idx_d   = idx_wrap;
                     scan_d  = '0;
                     state_d = SCAN;
                  end
`endif
               end
            end
         end
         SCAN: begin
`ifdef FOOD_SCAN_FALLBACK_EN
            if (bus.i_QryAck) begin
               if (!bus.i_QryOcc) begin
                  food_x_d   = map_x;
                  food_y_d   = map_y;
                  food_vld_d = 1'b1;
                  state_d    = IDLE;
               end else if (scan_q + 8'd1 == 8'(CELLS)) begin
                  full_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  scan_d = scan_q + 8'd1;
                  idx_d  = idx_wrap;
               end
            end
`else
            state_d = IDLE;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   assign qry_vld         = (state_q == QUERY) || (state_q == SCAN);
   assign bus.o_QryVld    = qry_vld;
   assign bus.o_QryX      = qry_vld ? map_x : '0;
   assign bus.o_QryY      = qry_vld ? map_y : '0;
   assign bus.o_FoodVld   = food_vld_q;
   assign bus.o_FoodX     = food_x_q;
   assign bus.o_FoodY     = food_y_q;
   assign bus.o_Busy      = (state_q != IDLE);
   assign bus.o_BoardFull = full_q;

endmodule
